relu_stream_ctrl: RTL
=====================

Name: relu_stream_ctrl

Overview:
- Frame-level sequencer for the ReLU activation stage.
- Accepts a start command carrying the frame length and a requantisation shift, then streams exactly that many accumulator words through ReLU, shift and saturate.
- Drives a registered valid/ready output stream and pulses done at the end of the frame.
- Sits between the conv accumulator output and the next layer's input buffer.

Parameters:
- DATA_IN_WIDTH, 32, signed accumulator word width.
- DATA_OUT_WIDTH, 16, signed activation output width; must be less than or equal to DATA_IN_WIDTH.
- CNT_WIDTH, 16, frame length and element counter width.
- SHIFT_WIDTH, 5, requantisation right-shift field width.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  start a frame; sampled only in IDLE.
- cfg_len  in  CNT_WIDTH  number of elements in the frame; latched on start.
- cfg_shift  in  SHIFT_WIDTH  arithmetic right-shift amount; latched on start.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse when the frame completes.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid and s_ready are both high.
- s_data  in  DATA_IN_WIDTH  signed accumulator word.
- m_valid  out  1  output word valid (registered).
- m_ready  in  1  downstream ready.
- m_data  out  DATA_OUT_WIDTH  signed activation (registered).
- m_last  out  1  marks the final element of the frame; qualified by m_valid.
- elem_cnt  out  CNT_WIDTH  number of inputs accepted in the current frame.

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, m_valid=0, m_data=0, m_last=0, elem_cnt=0; state=IDLE. Reset asserted mid-frame aborts the frame immediately; the pending output word is discarded and no done is produced.
- IDLE:
  - cfg_start=1 with cfg_len!=0: latch len and shift, clear elem_cnt, go to RUN.
  - cfg_start=1 with cfg_len=0: go to DONE directly; no output words.
  - cfg_start is ignored in every other state.
- RUN:
  - s_ready = !m_valid || m_ready (single-entry output register, full throughput).
  - On each input transfer: m_data <= sat(relu(s_data) >>> shift); m_valid <= 1; elem_cnt increments.
  - The transfer that makes elem_cnt equal len sets m_last=1, drives s_ready=0 from the next cycle and moves to DRAIN.
  - If m_ready=1 and no input transfer occurs in the same cycle, m_valid clears.
- DRAIN: s_ready=0. When m_valid && m_ready: clear m_valid and m_last, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy is low in IDLE only.
- Latency: one cycle from input transfer to m_valid. Throughput: 1 word per cycle while m_ready is held high.
- Output hold: m_data, m_valid and m_last remain stable while m_valid && !m_ready.
- Arithmetic:
  - relu(x) = x when x >= 0, else 0.
  - Shift is an arithmetic right shift of the DATA_IN_WIDTH value. Shift values at or above DATA_IN_WIDTH give 0.
  - sat clamps to 2^(DATA_OUT_WIDTH-1)-1; the result is never negative.
- Input words offered after the frame completes are not accepted; s_ready stays 0 outside RUN.

Optional Feature:
- Macro: RELU_SAT_EN.
- Defined: saturating clamp as described above; 0x7FFFFFFF with shift 0 gives 0x7FFF.
- Undefined: plain truncation to the low DATA_OUT_WIDTH bits with no clamp; 0x7FFFFFFF with shift 0 gives 0xFFFF. Area-reduced build for layers whose calibration guarantees no overflow.

Test Plan:
- Start with len=4, shift=0; inputs 5, -3, 0, 100 with m_ready=1 -> outputs 5, 0, 0, 100; m_last on the 4th output; done pulses 1 cycle after the last transfer; elem_cnt=4.
- Len=3, shift=4; inputs 0x100, 0x0F, -0x100 -> outputs 0x10, 0x0, 0x0.
- With RELU_SAT_EN: input 0x00012345, shift=0 -> 0x7FFF. Without RELU_SAT_EN: same input -> 0x2345.
- Len=8 with m_ready toggling every other cycle -> m_data held stable while stalled, no word lost or duplicated, s_ready=0 while m_valid && !m_ready; exactly 8 outputs.
- Start with len=0 -> no s_ready, no m_valid; done 1 cycle after DONE is entered; cfg_start pulsed during busy on another frame is ignored.
- Assert rst after 2 of 6 elements of a frame -> all outputs return to reset values at once and no done pulse; a new start with len=2 afterwards runs normally.

Source files
------------

// File: rtl/relu_stream_ctrl_if.sv
// Handshake bundle for relu_stream_ctrl: frame config, status, and the
// accumulator-in / activation-out valid-ready streams.
interface relu_stream_ctrl_if #(
  parameter int DATA_IN_WIDTH  = 32,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int SHIFT_WIDTH    = 5
);
  logic                      cfg_start;
  logic [CNT_WIDTH-1:0]      cfg_len;
  logic [SHIFT_WIDTH-1:0]    cfg_shift;
  logic                      busy;
  logic                      done;
  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_IN_WIDTH-1:0]  s_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_OUT_WIDTH-1:0] m_data;
  logic                      m_last;
  logic [CNT_WIDTH-1:0]      elem_cnt;

  // master: the side issuing frames, feeding words and draining results
  modport master (
    output cfg_start, cfg_len, cfg_shift, s_valid, s_data, m_ready,
    input  busy, done, s_ready, m_valid, m_data, m_last, elem_cnt
  );

  modport slave (
    input  cfg_start, cfg_len, cfg_shift, s_valid, s_data, m_ready,
    output busy, done, s_ready, m_valid, m_data, m_last, elem_cnt
  );
endinterface

// File: rtl/relu_stream_ctrl.sv
// Frame sequencer for the ReLU stage: relu, requant shift, clamp/truncate.
// RELU_SAT_EN defined: saturate to the max positive output; undefined: truncate.
module relu_stream_ctrl #(
  parameter int DATA_IN_WIDTH  = 32,
  parameter int DATA_OUT_WIDTH = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int SHIFT_WIDTH    = 5
) (
  input  logic               clk,
  input  logic               rst,
  relu_stream_ctrl_if.slave  bus
);
  localparam int DIN  = DATA_IN_WIDTH;
  localparam int DOUT = DATA_OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   len_q, cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   m_valid_q, m_last_q, busy_q, done_q;
  logic [DOUT-1:0]        m_data_q, m_data_d;
  logic [DIN-1:0]         relu_v, shr_v;
  logic                   s_ready, xfer;

`ifdef RELU_SAT_EN
  localparam logic [DIN-1:0] SAT_MAX = {{(DIN-DOUT+1){1'b0}}, {(DOUT-1){1'b1}}};
`endif

  always_comb begin
    s_ready = (state_q == RUN) && (!m_valid_q || bus.m_ready);
    xfer    = s_ready && bus.s_valid;
    cnt_d   = cnt_q + CNT_WIDTH'(1);
    relu_v  = bus.s_data[DIN-1] ? '0 : bus.s_data;
    // relu_v is non-negative, so a logical shift equals the arithmetic one,
    // and shifting by >= DIN already yields zero.
    shr_v   = relu_v >> shift_q;
`ifdef RELU_SAT_EN
    m_data_d = (shr_v > SAT_MAX) ? SAT_MAX[DOUT-1:0] : shr_v[DOUT-1:0];
`else
    m_data_d = shr_v[DOUT-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.cfg_start) begin
          len_q    <= bus.cfg_len;
          shift_q  <= bus.cfg_shift;
          cnt_q    <= '0;
          m_last_q <= 1'b0;
          busy_q   <= 1'b1;
          if (bus.cfg_len == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            m_data_q  <= m_data_d;
            m_valid_q <= 1'b1;
            cnt_q     <= cnt_d;
            if (cnt_d == len_q) begin
              m_last_q <= 1'b1;
              state_q  <= DRAIN;
            end
          end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
          end
        end
        DRAIN: if (m_valid_q && bus.m_ready) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          state_q   <= DONE;
          done_q    <= 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.elem_cnt = cnt_q;
endmodule
